// File: rtl/fp_int_acc.sv
// Floating-to-fixed accumulate step: aligns one FP term to the reference exponent,
// then adds it to or subtracts it from a 32-bit fixed-point accumulator value.
module fp_int_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign_in,
  input  logic [4:0]  exp_set,
  input  logic [31:0] fixed_point_acc,
  input  logic [4:0]  exp_in,
  input  logic [13:0] fixed_point_in,
  output logic [4:0]  exp_out,
  output logic [31:0] fixed_point_out
);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ADD} state_t;

  state_t      state_q, state_d;
  logic        capture_en, align_en, add_en;

  logic        sign_q, sign_d;
  logic [4:0]  exp_set_q, exp_set_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  exp_in_q, exp_in_d;
  logic [13:0] frac_q, frac_d;
  logic [31:0] aligned_q, aligned_d;
  logic [4:0]  exp_out_q, exp_out_d;
  logic [31:0] fp_out_q, fp_out_d;

  logic [31:0] term_ext, shifted, sum;
  logic [5:0]  shift_amt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    capture_en = (state_q == S_IDLE) && start;
    align_en   = (state_q == S_ALIGN);
    add_en     = (state_q == S_ADD);
  end

  // Shift distances of 32 or more flush the term entirely.
  always_comb begin
    term_ext  = {18'd0, frac_q};
    shifted   = term_ext;
    shift_amt = 6'd0;
    if (exp_in_q < exp_set_q) begin
      shift_amt = {1'b0, exp_set_q - exp_in_q};
      shifted   = (shift_amt >= 6'd32) ? 32'd0 : (term_ext >> shift_amt);
    end else if (exp_in_q > exp_set_q) begin
      shift_amt = {1'b0, exp_in_q - exp_set_q};
      shifted   = (shift_amt >= 6'd32) ? 32'd0 : (term_ext << shift_amt);
    end
  end

  always_comb begin
    sum = sign_q ? (acc_q - aligned_q) : (acc_q + aligned_q);
  end

  always_comb begin
    sign_d    = sign_q;
    exp_set_d = exp_set_q;
    acc_d     = acc_q;
    exp_in_d  = exp_in_q;
    frac_d    = frac_q;
    aligned_d = aligned_q;
    exp_out_d = exp_out_q;
    fp_out_d  = fp_out_q;
    if (capture_en) begin
      sign_d    = sign_in;
      exp_set_d = exp_set;
      acc_d     = fixed_point_acc;
      exp_in_d  = exp_in;
      frac_d    = fixed_point_in;
    end
    if (align_en) begin
      aligned_d = shifted;
    end
    if (add_en) begin
      fp_out_d  = sum;
      exp_out_d = exp_set_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q    <= 1'b0;
      exp_set_q <= 5'd0;
      acc_q     <= 32'd0;
      exp_in_q  <= 5'd0;
      frac_q    <= 14'd0;
      aligned_q <= 32'd0;
      exp_out_q <= 5'd0;
      fp_out_q  <= 32'd0;
    end else begin
      sign_q    <= sign_d;
      exp_set_q <= exp_set_d;
      acc_q     <= acc_d;
      exp_in_q  <= exp_in_d;
      frac_q    <= frac_d;
      aligned_q <= aligned_d;
      exp_out_q <= exp_out_d;
      fp_out_q  <= fp_out_d;
    end
  end

  assign exp_out         = exp_out_q;
  assign fixed_point_out = fp_out_q;

endmodule

// File: tb/tb_fp_int_acc.sv
// Directed self-checking bench for fp_int_acc with hand-computed expected results.
module tb_fp_int_acc;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign_in;
  logic [4:0]  exp_set;
  logic [31:0] fixed_point_acc;
  logic [4:0]  exp_in;
  logic [13:0] fixed_point_in;
  logic [4:0]  exp_out;
  logic [31:0] fixed_point_out;

  int n_checks = 0;
  int n_fail   = 0;

  fp_int_acc dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .sign_in         (sign_in),
    .exp_set         (exp_set),
    .fixed_point_acc (fixed_point_acc),
    .exp_in          (exp_in),
    .fixed_point_in  (fixed_point_in),
    .exp_out         (exp_out),
    .fixed_point_out (fixed_point_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic [4:0] es, input logic [31:0] acc,
                               input logic [4:0] ei, input logic [13:0] fin);
    sign_in         = s;
    exp_set         = es;
    fixed_point_acc = acc;
    exp_in          = ei;
    fixed_point_in  = fin;
    start           = 1'b1;
  endtask

  task automatic scrambleInputs();
    sign_in         = ~sign_in;
    exp_set         = exp_set ^ 5'h15;
    fixed_point_acc = fixed_point_acc ^ 32'hA5A5_5A5A;
    exp_in          = exp_in ^ 5'h0A;
    fixed_point_in  = fixed_point_in ^ 14'h2AAA;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] exp_e, input logic [31:0] exp_fp);
    n_checks++;
    assert (exp_out === exp_e) else begin
      n_fail++;
      $error("[TB] FAIL %s exp_out: observed %0d expected %0d", tag, exp_out, exp_e);
    end
    n_checks++;
    assert (fixed_point_out === exp_fp) else begin
      n_fail++;
      $error("[TB] FAIL %s fixed_point_out: observed 0x%08h expected 0x%08h", tag, fixed_point_out, exp_fp);
    end
  endtask

  // One complete operation: capture edge, inputs scrambled, then ALIGN and ADD edges.
  task automatic runOp(input logic s, input logic [4:0] es, input logic [31:0] acc,
                       input logic [4:0] ei, input logic [13:0] fin);
    applyStimulus(s, es, acc, ei, fin);
    @(posedge clk);
    #1;
    start = 1'b0;
    scrambleInputs();
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    sign_in         = 1'b0;
    exp_set         = 5'd0;
    fixed_point_acc = 32'd0;
    exp_in          = 5'd0;
    fixed_point_in  = 14'd0;

    #12;
    checkOutput("reset", 5'd0, 32'h0000_0000);
    rst = 1'b0;

    runOp(1'b0, 5'd16, 32'd1, 5'd15, 14'h21F6);
    checkOutput("right_shift_add", 5'd16, 32'h0000_10FC);

    runOp(1'b1, 5'd16, 32'd1, 5'd15, 14'h21F6);
    checkOutput("subtract", 5'd16, 32'hFFFF_EF06);

    runOp(1'b0, 5'd10, 32'd0, 5'd13, 14'h0003);
    checkOutput("left_shift", 5'd10, 32'h0000_0018);

    runOp(1'b0, 5'd5, 32'h10, 5'd5, 14'h3FFF);
    checkOutput("equal_exp", 5'd5, 32'h0000_400F);

    runOp(1'b0, 5'd31, 32'd7, 5'd0, 14'h3FFF);
    checkOutput("right_shift_31", 5'd31, 32'h0000_0007);

    runOp(1'b0, 5'd9, 32'h7FFF_FFFF, 5'd9, 14'h0001);
    checkOutput("wrap_add", 5'd9, 32'h8000_0000);

    runOp(1'b0, 5'd0, 32'd0, 5'd31, 14'h3FFF);
    checkOutput("left_shift_31", 5'd0, 32'h8000_0000);

    runOp(1'b1, 5'd3, 32'h8000_0000, 5'd3, 14'h0001);
    checkOutput("wrap_sub", 5'd3, 32'h7FFF_FFFF);

    // Busy: start held for two edges, inputs changed after capture.
    applyStimulus(1'b0, 5'd12, 32'h100, 5'd14, 14'h0005);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 5'd2, 32'hDEAD_0000, 5'd7, 14'h1234);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_hold_align", 5'd3, 32'h7FFF_FFFF);
    @(posedge clk);
    #1;
    checkOutput("busy_result", 5'd12, 32'h0000_0114);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("busy_not_queued", 5'd12, 32'h0000_0114);

    applyStimulus(1'b1, 5'd20, 32'd0, 5'd20, 14'h0002);
    @(posedge clk);
    #1;
    start = 1'b0;
    scrambleInputs();
    checkOutput("hold_after_capture", 5'd12, 32'h0000_0114);
    @(posedge clk);
    #1;
    checkOutput("hold_after_align", 5'd12, 32'h0000_0114);
    @(posedge clk);
    #1;
    checkOutput("next_result", 5'd20, 32'hFFFF_FFFE);

    // Reset asserted asynchronously while the operation is in ALIGN.
    applyStimulus(1'b0, 5'd8, 32'h55, 5'd8, 14'h0011);
    @(posedge clk);
    #1;
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 5'd0, 32'h0000_0000);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("no_partial_result", 5'd0, 32'h0000_0000);

    runOp(1'b0, 5'd4, 32'h1000, 5'd6, 14'h0007);
    checkOutput("after_reset_op", 5'd4, 32'h0000_101C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
